// File: rtl/pc_unit.sv
// Parametrised program counter with relative branches, a one-cycle page-cross
// fix-up, split high/low field access and tri-state address/data bus drivers.
module pc_unit #(
  parameter int                ADDR_N   = 16,
  parameter int                DATA_N   = 8,
  parameter logic [ADDR_N-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pc_addr_oe,
  output logic [ADDR_N-1:0] addr,
  input  logic              pc_inc,
  input  logic              br,
  input  logic              weh,
  input  logic              wel,
  input  logic [DATA_N-1:0] in,
  input  logic              oeh,
  input  logic              oel,
  output logic [DATA_N-1:0] out,
  output logic [ADDR_N-1:0] pc,
  output logic              busy,
  output logic              page_cross
);

  localparam int H = ADDR_N - DATA_N;

  typedef enum logic {
    IDLE = 1'b0,
    FIX  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_N-1:0] pc_q, pc_d;
  logic              adjDec_q, adjDec_d;

  logic [DATA_N-1:0] lowField;
  logic [H-1:0]      highField;
  logic [DATA_N:0]   brSum;

  assign lowField  = pc_q[DATA_N-1:0];
  assign highField = pc_q[ADDR_N-1:DATA_N];
  assign brSum     = {1'b0, lowField} + {1'b0, in};

  // A carry that disagrees with the offset sign means the target sits on the
  // neighbouring page; the high field is corrected one cycle later in FIX.
  always_comb begin
    pc_d     = pc_q;
    state_d  = state_q;
    adjDec_d = adjDec_q;
    case (state_q)
      IDLE: begin
        if (br) begin
          pc_d[DATA_N-1:0] = brSum[DATA_N-1:0];
          if (brSum[DATA_N] != in[DATA_N-1]) begin
            state_d  = FIX;
            adjDec_d = in[DATA_N-1];
          end
        end else if (pc_inc) begin
          pc_d = pc_q + ADDR_N'(1);
        end else begin
          if (weh) pc_d[ADDR_N-1:DATA_N] = in[H-1:0];
          if (wel) pc_d[DATA_N-1:0]      = in;
        end
      end
      FIX: begin
        pc_d[ADDR_N-1:DATA_N] = adjDec_q ? highField - H'(1) : highField + H'(1);
        state_d               = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      state_q  <= IDLE;
      adjDec_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      state_q  <= state_d;
      adjDec_q <= adjDec_d;
    end
  end

  assign pc         = pc_q;
  assign busy       = (state_q == FIX);
  assign page_cross = (state_q == FIX);

  // The high field reads back zero-extended; oeh takes precedence over oel.
  assign addr = pc_addr_oe ? pc_q : {ADDR_N{1'bz}};
  assign out  = oeh ? DATA_N'(highField) :
                oel ? lowField : {DATA_N{1'bz}};

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: a 16-bit instance driven from a vector table plus
// hand sequences, and a 12-bit instance for the narrow high-field wrap case.
module tb_pc_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 16-bit instance, RESET_PC = FFFC
  logic        reset16 = 1'b0, oe16 = 1'b0, inc16 = 1'b0, br16 = 1'b0;
  logic        weh16 = 1'b0, wel16 = 1'b0, oeh16 = 1'b0, oel16 = 1'b0;
  logic [7:0]  in16 = '0;
  wire  [15:0] addr16;
  wire  [7:0]  out16;
  logic [15:0] pc16;
  logic        busy16, cross16;

  pc_unit #(.ADDR_N(16), .DATA_N(8), .RESET_PC(16'hFFFC)) dut16 (
    .clk(clk), .reset(reset16), .pc_addr_oe(oe16), .addr(addr16),
    .pc_inc(inc16), .br(br16), .weh(weh16), .wel(wel16), .in(in16),
    .oeh(oeh16), .oel(oel16), .out(out16), .pc(pc16),
    .busy(busy16), .page_cross(cross16)
  );

  // 12-bit instance, RESET_PC = 000
  logic        reset12 = 1'b0, inc12 = 1'b0, br12 = 1'b0;
  logic        weh12 = 1'b0, wel12 = 1'b0, oeh12 = 1'b0;
  logic [7:0]  in12 = '0;
  wire  [11:0] addr12;
  wire  [7:0]  out12;
  logic [11:0] pc12;
  logic        busy12, cross12;

  pc_unit #(.ADDR_N(12), .DATA_N(8), .RESET_PC(12'h000)) dut12 (
    .clk(clk), .reset(reset12), .pc_addr_oe(1'b1), .addr(addr12),
    .pc_inc(inc12), .br(br12), .weh(weh12), .wel(wel12), .in(in12),
    .oeh(oeh12), .oel(1'b0), .out(out12), .pc(pc12),
    .busy(busy12), .page_cross(cross12)
  );

  typedef struct {
    string       name;
    logic        rst, br, inc, weh, wel;
    logic [7:0]  din;
    logic        oeh, oel, oe;
    logic [15:0] expPc;
    logic        expBusy;
    logic        chkOut;
    logic [7:0]  expOut;
    logic        chkZ;
  } vec_t;

  int   applied = 0;
  int   miscompares = 0;
  vec_t vecs[$];

  function automatic vec_t mk(string name, logic rst, logic br, logic inc,
                              logic weh, logic wel, logic [7:0] din,
                              logic oeh, logic oel, logic oe,
                              logic [15:0] expPc, logic expBusy,
                              logic chkOut, logic [7:0] expOut, logic chkZ);
    vec_t v;
    v.name = name; v.rst = rst; v.br = br; v.inc = inc; v.weh = weh; v.wel = wel;
    v.din = din; v.oeh = oeh; v.oel = oel; v.oe = oe; v.expPc = expPc;
    v.expBusy = expBusy; v.chkOut = chkOut; v.expOut = expOut; v.chkZ = chkZ;
    return v;
  endfunction

  task automatic compare(string name, logic [15:0] act, logic [15:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkOutput(vec_t v);
    compare({v.name, ".pc"}, pc16, v.expPc);
    compare({v.name, ".busy"}, {15'd0, busy16}, {15'd0, v.expBusy});
    compare({v.name, ".page_cross"}, {15'd0, cross16}, {15'd0, v.expBusy});
    if (v.oe) compare({v.name, ".addr"}, addr16, v.expPc);
    if (v.chkOut) compare({v.name, ".out"}, {8'd0, out16}, {8'd0, v.expOut});
    if (v.chkZ) begin
      applied++;
      if (out16 === v.expPc[7:0] || addr16 === v.expPc) begin
        miscompares++;
        $display("[TB] FAIL %s.release: out %h addr %h still carry pc %h",
                 v.name, out16, addr16, v.expPc);
      end
    end
  endtask

  task automatic applyStimulus(vec_t v);
    @(negedge clk);
    reset16 = v.rst; br16 = v.br; inc16 = v.inc; weh16 = v.weh; wel16 = v.wel;
    in16 = v.din; oeh16 = v.oeh; oel16 = v.oel; oe16 = v.oe;
    @(posedge clk);
    #1;
    checkOutput(v);
  endtask

  task automatic step12(string name, logic rst, logic br, logic weh, logic wel,
                        logic [7:0] din, logic oeh, logic [11:0] expPc,
                        logic expBusy, logic chkOut, logic [7:0] expOut);
    @(negedge clk);
    reset12 = rst; br12 = br; inc12 = 1'b0; weh12 = weh; wel12 = wel;
    in12 = din; oeh12 = oeh;
    @(posedge clk);
    #1;
    compare({name, ".pc"}, {4'd0, pc12}, {4'd0, expPc});
    compare({name, ".addr"}, {4'd0, addr12}, {4'd0, expPc});
    compare({name, ".busy"}, {15'd0, busy12}, {15'd0, expBusy});
    compare({name, ".page_cross"}, {15'd0, cross12}, {15'd0, expBusy});
    if (chkOut) compare({name, ".out"}, {8'd0, out12}, {8'd0, expOut});
  endtask

  initial begin
    //                name       rst br inc weh wel din    oeh oel oe  expPc     bsy chkO expOut chkZ
    vecs.push_back(mk("reset",    1, 0, 0, 0, 0, 8'h00, 0, 0, 1, 16'hFFFC, 0, 0, 8'h00, 0));
    vecs.push_back(mk("inc1",     0, 0, 1, 0, 0, 8'h00, 0, 0, 0, 16'hFFFD, 0, 0, 8'h00, 0));
    vecs.push_back(mk("inc2",     0, 0, 1, 0, 0, 8'h00, 0, 0, 0, 16'hFFFE, 0, 0, 8'h00, 0));
    vecs.push_back(mk("inc3",     0, 0, 1, 0, 0, 8'h00, 0, 0, 0, 16'hFFFF, 0, 0, 8'h00, 0));
    vecs.push_back(mk("incWrap",  0, 0, 1, 0, 0, 8'h00, 0, 0, 1, 16'h0000, 0, 0, 8'h00, 0));
    vecs.push_back(mk("inc5",     0, 0, 1, 0, 0, 8'h00, 0, 0, 0, 16'h0001, 0, 0, 8'h00, 0));
    vecs.push_back(mk("brOverInc",0, 1, 1, 0, 0, 8'h02, 0, 0, 0, 16'h0003, 0, 0, 8'h00, 0));
    vecs.push_back(mk("incOverWr",0, 0, 1, 1, 1, 8'h55, 0, 0, 0, 16'h0004, 0, 0, 8'h00, 0));
    vecs.push_back(mk("wehOnly",  0, 0, 0, 1, 0, 8'h12, 0, 0, 0, 16'h1204, 0, 0, 8'h00, 0));
    vecs.push_back(mk("welOnly",  0, 0, 0, 0, 1, 8'h34, 0, 0, 1, 16'h1234, 0, 0, 8'h00, 0));
    vecs.push_back(mk("wBoth",    0, 0, 0, 1, 1, 8'hAB, 1, 0, 1, 16'hABAB, 0, 1, 8'hAB, 0));
    vecs.push_back(mk("holdOel",  0, 0, 0, 0, 0, 8'h00, 0, 1, 0, 16'hABAB, 0, 1, 8'hAB, 0));
    vecs.push_back(mk("oehWins",  0, 0, 0, 1, 0, 8'hCD, 1, 1, 1, 16'hCDAB, 0, 1, 8'hCD, 0));
    vecs.push_back(mk("release",  0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 16'hCDAB, 0, 0, 8'h00, 1));
    vecs.push_back(mk("setHi12",  0, 0, 0, 1, 0, 8'h12, 0, 0, 0, 16'h12AB, 0, 0, 8'h00, 0));
    vecs.push_back(mk("setLo10",  0, 0, 0, 0, 1, 8'h10, 0, 0, 0, 16'h1210, 0, 0, 8'h00, 0));
    vecs.push_back(mk("brFwd",    0, 1, 0, 0, 0, 8'h05, 0, 0, 1, 16'h1215, 0, 0, 8'h00, 0));
    vecs.push_back(mk("setLo10b", 0, 0, 0, 0, 1, 8'h10, 0, 0, 0, 16'h1210, 0, 0, 8'h00, 0));
    vecs.push_back(mk("brBack",   0, 1, 0, 0, 0, 8'hF0, 0, 0, 0, 16'h1200, 0, 0, 8'h00, 0));
    vecs.push_back(mk("setLoF0",  0, 0, 0, 0, 1, 8'hF0, 0, 0, 0, 16'h12F0, 0, 0, 8'h00, 0));
    vecs.push_back(mk("brXfwd1",  0, 1, 0, 0, 0, 8'h20, 1, 0, 1, 16'h1210, 1, 1, 8'h12, 0));
    vecs.push_back(mk("brXfwd2",  0, 0, 0, 0, 0, 8'h00, 0, 0, 1, 16'h1310, 0, 0, 8'h00, 0));
    vecs.push_back(mk("setLo05",  0, 0, 0, 0, 1, 8'h05, 0, 0, 0, 16'h1305, 0, 0, 8'h00, 0));
    vecs.push_back(mk("setHi12b", 0, 0, 0, 1, 0, 8'h12, 0, 0, 0, 16'h1205, 0, 0, 8'h00, 0));
    vecs.push_back(mk("brXback1", 0, 1, 0, 0, 0, 8'hF0, 0, 1, 0, 16'h12F5, 1, 1, 8'hF5, 0));
    vecs.push_back(mk("brXback2", 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 16'h11F5, 0, 0, 8'h00, 0));

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Commands during FIX must be ignored; the branch target survives.
    applyStimulus(mk("fixSetLo", 0, 0, 0, 0, 1, 8'hF0, 0, 0, 0, 16'h11F0, 0, 0, 8'h00, 0));
    applyStimulus(mk("fixSetHi", 0, 0, 0, 1, 0, 8'h12, 0, 0, 0, 16'h12F0, 0, 0, 8'h00, 0));
    applyStimulus(mk("fixBr",    0, 1, 0, 0, 0, 8'h20, 0, 0, 0, 16'h1210, 1, 0, 8'h00, 0));
    applyStimulus(mk("fixIgnore",0, 1, 1, 1, 1, 8'h55, 0, 0, 1, 16'h1310, 0, 0, 8'h00, 0));

    // Reset arriving mid-FIX wins over the pending high-field correction.
    applyStimulus(mk("rstSetLo", 0, 0, 0, 0, 1, 8'hF0, 0, 0, 0, 16'h13F0, 0, 0, 8'h00, 0));
    applyStimulus(mk("rstBr",    0, 1, 0, 0, 0, 8'h20, 0, 0, 0, 16'h1310, 1, 0, 8'h00, 0));
    applyStimulus(mk("rstInFix", 1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 16'hFFFC, 0, 0, 8'h00, 0));
    applyStimulus(mk("rstHold",  0, 0, 0, 0, 0, 8'h00, 0, 0, 1, 16'hFFFC, 0, 0, 8'h00, 0));

    // Narrow instance: 4-bit high field wraps modulo 16.
    step12("n.reset", 1, 0, 0, 0, 8'h00, 0, 12'h000, 0, 0, 8'h00);
    step12("n.setHi", 0, 0, 1, 0, 8'hFF, 0, 12'hF00, 0, 0, 8'h00);
    step12("n.setLo", 0, 0, 0, 1, 8'hF0, 0, 12'hFF0, 0, 0, 8'h00);
    step12("n.br1",   0, 1, 0, 0, 8'h20, 0, 12'hF10, 1, 0, 8'h00);
    step12("n.br2",   0, 0, 0, 0, 8'h00, 0, 12'h010, 0, 0, 8'h00);
    step12("n.wehA7", 0, 0, 1, 0, 8'hA7, 1, 12'h710, 0, 1, 8'h07);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
